mm_arbiter_2ch: RTL and testbench

Two-requester arbiter that shares one matrix-vector multiplier (8x8 weight memory, 8-entry X vector, 8 result beats per job) between two independent clients. It sits in front of the multiplier controller: it grants one requester a whole job, passes its input beats through unchanged, and returns the job's 8 result beats to the same requester. Only one job is in flight at a time. Arbitration is round-robin at job boundaries.

---
 rtl/mm_arbiter_2ch.sv | 159 +++++++++++++++
 tb/tb_mm_arbiter_2ch.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mm_arbiter_2ch.sv
// Two-client, job-granular round-robin arbiter in front of a shared matrix-vector multiplier.
// Input beats and result beats pass through combinationally to/from the granted client.
module mm_arbiter_2ch #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s0_valid,
  output logic              s0_ready,
  input  logic              s0_new_matrix,
  input  logic [DATA_W-1:0] s0_data,
  input  logic              s1_valid,
  output logic              s1_ready,
  input  logic              s1_new_matrix,
  input  logic [DATA_W-1:0] s1_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_new_matrix,
  output logic [DATA_W-1:0] m_data,
  input  logic              r_valid,
  output logic              r_ready,
  input  logic [ACC_W-1:0]  r_data,
  output logic              d0_valid,
  input  logic              d0_ready,
  output logic [ACC_W-1:0]  d0_data,
  output logic              d1_valid,
  input  logic              d1_ready,
  output logic [ACC_W-1:0]  d1_data,
  output logic [1:0]        grant,
  output logic              w_owner,
  output logic              w_loaded,
  output logic              wt_mismatch
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StIn   = 2'd1;
  localparam logic [1:0] StOut  = 2'd2;

  logic [1:0] state_q, state_d;
  logic       gidx_q, gidx_d;
  logic       ptr_q, ptr_d;
  logic [6:0] beat_cnt_q, beat_cnt_d;
  logic [2:0] res_cnt_q, res_cnt_d;
  logic       wx_q, wx_d;
  logic       w_owner_q, w_owner_d;
  logic       w_loaded_q, w_loaded_d;

  logic              in_st, out_st;
  logic              g_valid, g_nm, g_dready;
  logic [DATA_W-1:0] g_data;
  logic              in_hs, out_hs, first_beat, job_wx, last_in, pick;

  assign in_st  = (state_q == StIn);
  assign out_st = (state_q == StOut);

  assign g_valid  = gidx_q ? s1_valid : s0_valid;
  assign g_nm     = gidx_q ? s1_new_matrix : s0_new_matrix;
  assign g_data   = gidx_q ? s1_data : s0_data;
  assign g_dready = gidx_q ? d1_ready : d0_ready;

  assign m_valid      = in_st & g_valid;
  assign m_new_matrix = in_st & g_nm;
  assign m_data       = in_st ? g_data : '0;
  assign s0_ready     = in_st & ~gidx_q & m_ready;
  assign s1_ready     = in_st & gidx_q & m_ready;

  assign r_ready  = out_st & g_dready;
  assign d0_valid = out_st & ~gidx_q & r_valid;
  assign d1_valid = out_st & gidx_q & r_valid;
  assign d0_data  = (out_st & ~gidx_q) ? r_data : '0;
  assign d1_data  = (out_st & gidx_q) ? r_data : '0;

  assign in_hs      = m_valid & m_ready;
  assign out_hs     = r_valid & r_ready;
  assign first_beat = (beat_cnt_q == 7'd0);
  // Job type is only known once the first beat is on the bus.
  assign job_wx     = first_beat ? g_nm : wx_q;
  assign last_in    = job_wx ? (beat_cnt_q == 7'd71) : (beat_cnt_q == 7'd7);
  assign pick       = (s0_valid & s1_valid) ? ptr_q : s1_valid;

  assign grant       = (state_q == StIdle) ? 2'b00 : (gidx_q ? 2'b10 : 2'b01);
  assign w_owner     = w_owner_q;
  assign w_loaded    = w_loaded_q;
  assign wt_mismatch = in_hs & first_beat & ~g_nm & (~w_loaded_q | (w_owner_q != gidx_q));

  always_comb begin
    state_d    = state_q;
    gidx_d     = gidx_q;
    ptr_d      = ptr_q;
    beat_cnt_d = beat_cnt_q;
    res_cnt_d  = res_cnt_q;
    wx_d       = wx_q;
    w_owner_d  = w_owner_q;
    w_loaded_d = w_loaded_q;
    unique case (state_q)
      StIdle: begin
        if (s0_valid | s1_valid) begin
          gidx_d     = pick;
          state_d    = StIn;
          beat_cnt_d = 7'd0;
        end
      end
      StIn: begin
        if (in_hs) begin
          if (first_beat) begin
            wx_d = g_nm;
            if (g_nm) begin
              w_owner_d  = gidx_q;
              w_loaded_d = 1'b1;
            end
          end
          if (last_in) begin
            state_d    = StOut;
            beat_cnt_d = 7'd0;
            res_cnt_d  = 3'd0;
          end else begin
            beat_cnt_d = beat_cnt_q + 7'd1;
          end
        end
      end
      StOut: begin
        if (out_hs) begin
          if (res_cnt_q == 3'd7) begin
            state_d   = StIdle;
            ptr_d     = ~gidx_q;
            res_cnt_d = 3'd0;
          end else begin
            res_cnt_d = res_cnt_q + 3'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      gidx_q     <= 1'b0;
      ptr_q      <= 1'b0;
      beat_cnt_q <= 7'd0;
      res_cnt_q  <= 3'd0;
      wx_q       <= 1'b0;
      w_owner_q  <= 1'b0;
      w_loaded_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      gidx_q     <= gidx_d;
      ptr_q      <= ptr_d;
      beat_cnt_q <= beat_cnt_d;
      res_cnt_q  <= res_cnt_d;
      wx_q       <= wx_d;
      w_owner_q  <= w_owner_d;
      w_loaded_q <= w_loaded_d;
    end
  end

endmodule

// File: tb/tb_mm_arbiter_2ch.sv
// Randomised bench for mm_arbiter_2ch: a job-level model predicts every output each cycle,
// and directed scenarios pin the model with literal expectations.
module tb_mm_arbiter_2ch;

  logic        clk;
  logic        rst;
  logic [1:0]  sv, snm, d_ready;
  logic [7:0]  sd [2];
  logic        m_ready, r_valid;
  logic [31:0] r_data;
  logic        s0_ready, s1_ready, m_valid, m_new_matrix, r_ready;
  logic        d0_valid, d1_valid, w_owner, w_loaded, wt_mismatch;
  logic [7:0]  m_data;
  logic [31:0] d0_data, d1_data;
  logic [1:0]  grant;

  mm_arbiter_2ch #(.DATA_W(8), .ACC_W(32)) dut (
    .clk(clk), .rst(rst),
    .s0_valid(sv[0]), .s0_ready(s0_ready), .s0_new_matrix(snm[0]), .s0_data(sd[0]),
    .s1_valid(sv[1]), .s1_ready(s1_ready), .s1_new_matrix(snm[1]), .s1_data(sd[1]),
    .m_valid(m_valid), .m_ready(m_ready), .m_new_matrix(m_new_matrix), .m_data(m_data),
    .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data),
    .d0_valid(d0_valid), .d0_ready(d_ready[0]), .d0_data(d0_data),
    .d1_valid(d1_valid), .d1_ready(d_ready[1]), .d1_data(d1_data),
    .grant(grant), .w_owner(w_owner), .w_loaded(w_loaded), .wt_mismatch(wt_mismatch)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // Job-level model: owner (-1 idle), input beats left (-1 = type not yet seen), results left.
  int owner, in_left, out_left, pref, res_job;
  bit wl, wo;
  bit hs_in, hs_out;
  int ho;

  // Client and environment knobs.
  bit [1:0] cl_act;
  bit       cl_nm [2];
  int       cl_sent [2];
  int       cl_jobs [2];
  int       cl_p [2];
  int       mr_p, rv_p, dr_p;
  bit       data_rand, rst_req;

  // Observations of the DUT for the directed literal checks.
  int          in_cnt [2];
  int          d_cnt [2];
  int          mis_cnt;
  logic [7:0]  mq [$];
  logic [31:0] dq [$];
  int          dcyc [$];
  logic [1:0]  gseq [$];
  int          gcyc [$];
  logic [1:0]  prev_grant;
  logic [1:0]  cur_grant;
  logic        cur_s1r, cur_wl, cur_wo, cur_mv, cur_mis;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    owner = -1; in_left = 0; out_left = 0; pref = 0; res_job = 0; wl = 0; wo = 0;
    cl_act = '0; cl_sent[0] = 0; cl_sent[1] = 0;
  endtask

  task automatic start_job(input int k, input bit nm, input int jobs);
    cl_act[k] = 1'b1; cl_nm[k] = nm; cl_sent[k] = 0; cl_jobs[k] = jobs;
  endtask

  task automatic clear_obs();
    in_cnt[0] = 0; in_cnt[1] = 0; d_cnt[0] = 0; d_cnt[1] = 0; mis_cnt = 0;
    mq.delete(); dq.delete(); dcyc.delete(); gseq.delete(); gcyc.delete();
  endtask

  task automatic drive();
    for (int k = 0; k < 2; k++) begin
      if (cl_act[k] && ($urandom_range(99) < cl_p[k])) begin
        sv[k] = 1'b1; snm[k] = cl_nm[k];
        sd[k] = data_rand ? 8'($urandom) : 8'(cl_sent[k]);
      end else begin
        sv[k] = 1'b0; snm[k] = 1'($urandom); sd[k] = 8'($urandom);
      end
      d_ready[k] = ($urandom_range(99) < dr_p);
    end
    m_ready = ($urandom_range(99) < mr_p);
    r_valid = ($urandom_range(99) < rv_p);
    r_data  = 32'(100 + res_job);
    rst     = rst_req;
  endtask

  task automatic compare();
    bit in_ph, out_ph;
    int o;
    in_ph  = (owner >= 0) && (in_left != 0);
    out_ph = (owner >= 0) && (in_left == 0);
    o      = (owner < 0) ? 0 : owner;
    hs_in  = in_ph && sv[o] && m_ready;
    hs_out = out_ph && r_valid && d_ready[o];
    ho     = o;
    chk("grant", 32'(grant), (owner < 0) ? 32'd0 : ((owner == 0) ? 32'd1 : 32'd2));
    chk("m_valid", 32'(m_valid), 32'(in_ph && sv[o]));
    chk("m_data", 32'(m_data), in_ph ? 32'(sd[o]) : 32'd0);
    chk("m_new_matrix", 32'(m_new_matrix), in_ph ? 32'(snm[o]) : 32'd0);
    chk("s0_ready", 32'(s0_ready), 32'(in_ph && o == 0 && m_ready));
    chk("s1_ready", 32'(s1_ready), 32'(in_ph && o == 1 && m_ready));
    chk("r_ready", 32'(r_ready), 32'(out_ph && d_ready[o]));
    chk("d0_valid", 32'(d0_valid), 32'(out_ph && o == 0 && r_valid));
    chk("d1_valid", 32'(d1_valid), 32'(out_ph && o == 1 && r_valid));
    chk("d0_data", d0_data, (out_ph && o == 0) ? r_data : 32'd0);
    chk("d1_data", d1_data, (out_ph && o == 1) ? r_data : 32'd0);
    chk("w_owner", 32'(w_owner), 32'(wo));
    chk("w_loaded", 32'(w_loaded), 32'(wl));
    chk("wt_mismatch", 32'(wt_mismatch),
        32'(hs_in && in_left < 0 && !snm[o] && (!wl || int'(wo) != o)));
    if (s0_ready && sv[0]) in_cnt[0]++;
    if (s1_ready && sv[1]) in_cnt[1]++;
    if (m_valid && m_ready) mq.push_back(m_data);
    if (d0_valid && d_ready[0]) begin d_cnt[0]++; dq.push_back(d0_data); dcyc.push_back(cyc); end
    if (d1_valid && d_ready[1]) d_cnt[1]++;
    if (wt_mismatch) mis_cnt++;
    if (grant != 2'b00 && prev_grant == 2'b00) begin gseq.push_back(grant); gcyc.push_back(cyc); end
    prev_grant = grant;
    cur_grant = grant; cur_s1r = s1_ready; cur_wl = w_loaded; cur_wo = w_owner;
    cur_mv = m_valid; cur_mis = wt_mismatch;
  endtask

  task automatic update();
    if (rst_req) begin
      model_reset();
    end else begin
      if (owner < 0) begin
        if (sv[0] && sv[1]) owner = pref;
        else if (sv[0]) owner = 0;
        else if (sv[1]) owner = 1;
        if (owner >= 0) begin in_left = -1; out_left = 8; end
      end else if (hs_in) begin
        if (in_left < 0) begin
          if (snm[ho]) begin wo = ho[0]; wl = 1'b1; end
          in_left = snm[ho] ? 71 : 7;
        end else begin
          in_left--;
        end
        cl_sent[ho]++;
        if (cl_sent[ho] == (cl_nm[ho] ? 72 : 8)) begin
          cl_sent[ho] = 0;
          cl_jobs[ho]--;
          if (cl_jobs[ho] == 0) cl_act[ho] = 1'b0;
        end
      end else if (hs_out) begin
        out_left--;
        res_job = (res_job + 1) % 8;
        if (out_left == 0) begin pref = 1 - owner; owner = -1; end
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    drive();
    #1;
    compare();
    @(posedge clk);
    update();
    cyc++;
  endtask

  task automatic run_until_done(input string name, input int limit);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while ((cl_act != 2'b00 || owner >= 0) && n < limit);
    if (n >= limit) begin
      checks++; errors++;
      $display("FAIL %s timeout after %0d cycles, want completion", name, n);
    end
  endtask

  task automatic set_env(input int p0, input int p1, input int mr, input int rv, input int dr);
    cl_p[0] = p0; cl_p[1] = p1; mr_p = mr; rv_p = rv; dr_p = dr;
  endtask

  initial begin
    model_reset();
    rst_req = 1'b0; data_rand = 1'b0; prev_grant = 2'b00;
    set_env(100, 100, 100, 100, 100);
    clear_obs();
    rst = 1'b1; sv = '0; snm = '0; sd[0] = '0; sd[1] = '0;
    m_ready = 1'b0; r_valid = 1'b0; r_data = '0; d_ready = '0;
    repeat (2) @(posedge clk);

    // Reset values.
    step();
    chk("reset_grant", 32'(cur_grant), 32'd0);
    chk("reset_w_loaded", 32'(cur_wl), 32'd0);
    chk("reset_w_owner", 32'(cur_wo), 32'd0);
    chk("reset_m_valid", 32'(cur_mv), 32'd0);
    chk("reset_mismatch", 32'(cur_mis), 32'd0);

    // X-only job with no weights loaded.
    clear_obs();
    start_job(0, 1'b0, 1);
    run_until_done("xonly_first", 200);
    chk("xonly_first_mismatch", 32'(mis_cnt), 32'd1);
    chk("xonly_first_in", 32'(in_cnt[0]), 32'd8);
    chk("xonly_first_d0", 32'(d_cnt[0]), 32'd8);
    chk("xonly_first_wl", 32'(cur_wl), 32'd0);

    // W+X job with beat-index data.
    clear_obs();
    start_job(0, 1'b1, 1);
    run_until_done("wx_s0", 400);
    chk("wx_s0_in", 32'(in_cnt[0]), 32'd72);
    chk("wx_s0_d0", 32'(d_cnt[0]), 32'd8);
    chk("wx_s0_d1", 32'(d_cnt[1]), 32'd0);
    chk("wx_s0_wo", 32'(cur_wo), 32'd0);
    chk("wx_s0_wl", 32'(cur_wl), 32'd1);
    chk("wx_s0_mq_len", 32'(mq.size()), 32'd72);
    for (int i = 0; i < mq.size() && i < 72; i++) chk("wx_s0_mdata", 32'(mq[i]), 32'(i));
    chk("wx_s0_dq_len", 32'(dq.size()), 32'd8);
    for (int i = 0; i < dq.size() && i < 8; i++) chk("wx_s0_ddata", dq[i], 32'(100 + i));

    // X-only job from the non-owner.
    clear_obs();
    start_job(1, 1'b0, 1);
    run_until_done("xonly_s1", 200);
    chk("xonly_s1_mismatch", 32'(mis_cnt), 32'd1);
    chk("xonly_s1_in", 32'(in_cnt[1]), 32'd8);
    chk("xonly_s1_d1", 32'(d_cnt[1]), 32'd8);
    chk("xonly_s1_wo", 32'(cur_wo), 32'd0);

    // Heavy backpressure on both sides.
    clear_obs();
    data_rand = 1'b1;
    set_env(70, 100, 50, 70, 50);
    start_job(0, 1'b1, 1);
    run_until_done("stall", 2000);
    chk("stall_in", 32'(in_cnt[0]), 32'd72);
    chk("stall_d0", 32'(d_cnt[0]), 32'd8);
    chk("stall_d1", 32'(d_cnt[1]), 32'd0);

    // Both requesting from reset.
    set_env(100, 100, 100, 100, 100);
    rst_req = 1'b1; step(); rst_req = 1'b0;
    clear_obs();
    start_job(0, 1'b1, 2);
    start_job(1, 1'b1, 1);
    run_until_done("both", 1000);
    chk("both_gseq_len", 32'(gseq.size()), 32'd3);
    if (gseq.size() == 3) begin
      chk("both_first", 32'(gseq[0]), 32'd1);
      chk("both_second", 32'(gseq[1]), 32'd2);
      chk("both_third", 32'(gseq[2]), 32'd1);
    end
    if (dcyc.size() >= 8 && gcyc.size() >= 2) chk("both_gap", 32'(gcyc[1] - dcyc[7]), 32'd2);
    else chk("both_gap_data", 32'(dcyc.size()), 32'd16);

    // Reset in the middle of an s1 input phase.
    clear_obs();
    start_job(1, 1'b1, 1);
    begin
      int n;
      n = 0;
      while (cl_sent[1] < 30 && n < 300) begin step(); n++; end
      if (n >= 300) begin
        checks++; errors++;
        $display("FAIL midrst timeout waiting for beat 30, sent=%0d want 30", cl_sent[1]);
      end
    end
    rst_req = 1'b1; step(); rst_req = 1'b0;
    step();
    chk("midrst_grant", 32'(cur_grant), 32'd0);
    chk("midrst_s1_ready", 32'(cur_s1r), 32'd0);
    chk("midrst_wl", 32'(cur_wl), 32'd0);
    clear_obs();
    start_job(0, 1'b1, 1);
    run_until_done("midrst_s0", 400);
    chk("midrst_s0_in", 32'(in_cnt[0]), 32'd72);
    chk("midrst_s0_d0", 32'(d_cnt[0]), 32'd8);

    // Random contention rounds.
    for (int r = 0; r < 8; r++) begin
      set_env($urandom_range(30, 100), $urandom_range(30, 100), $urandom_range(30, 100),
              $urandom_range(30, 100), $urandom_range(30, 100));
      start_job(0, 1'($urandom), int'($urandom_range(1, 2)));
      start_job(1, 1'($urandom), int'($urandom_range(1, 2)));
      run_until_done("random", 5000);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
